nonce_sched: RTL and testbench



---
 rtl/nonce_sched_pkg.sv | 10 +
 rtl/nonce_sched_target_cmp.sv | 10 +
 rtl/nonce_sched.sv | 98 +++++++++
 tb/tb_nonce_sched.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/nonce_sched_pkg.sv
// nonce_sched_pkg: shared widths, FSM state encoding and target hit compare
package nonce_sched_pkg;
  localparam int NONCE_W = 32;
  localparam int HASH_W  = 24;
  localparam int TGT_W   = 8;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, DONE} state_e;
  function automatic logic is_hit(input logic [HASH_W-1:0] hash, input logic [TGT_W-1:0] tgt);
    return hash[HASH_W-1 -: TGT_W] < tgt;
  endfunction
endpackage

// File: rtl/nonce_sched_target_cmp.sv
// target_cmp: combinational check of a hash's top bits against the target
module target_cmp
  import nonce_sched_pkg::*;
(
  input  logic [HASH_W-1:0] hash_i,
  input  logic [TGT_W-1:0]  target_i,
  output logic              hit_o
);
  assign hit_o = is_hit(hash_i, target_i);
endmodule

// File: rtl/nonce_sched.sv
// nonce_sched: walks nonces through the hash core until a target hit or the budget runs out
module nonce_sched
  import nonce_sched_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         num_entradas,
  input  logic [TGT_W-1:0]   target,
  input  logic [NONCE_W-1:0] nonce_base,
  input  logic [NONCE_W-1:0] max_iter,
  output logic               core_start,
  output logic [NONCE_W-1:0] core_nonce,
  output logic [1:0]         core_blocks,
  input  logic               core_done,
  input  logic [HASH_W-1:0]  core_hash,
  output logic               busy,
  output logic               fin,
  output logic               found,
  output logic [NONCE_W-1:0] nonce_valido_out,
  output logic [HASH_W-1:0]  bounty_out,
  output logic [NONCE_W-1:0] iter_count
);
  state_e             state_q, state_d;
  logic [NONCE_W-1:0] nonce_q, max_q, iter_q, nvo_q;
  logic [TGT_W-1:0]   tgt_q;
  logic [HASH_W-1:0]  bounty_q;
  logic [1:0]         blocks_q;
  logic               found_q, hit;

  target_cmp u_cmp (.hash_i(bounty_q), .target_i(tgt_q), .hit_o(hit));

  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;

  // next state; abort from any busy state wins over every other decision
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? ((max_iter != '0) ? ISSUE : DONE) : IDLE;
      ISSUE:   state_d = abort ? IDLE : WAIT;
      WAIT:    state_d = abort ? IDLE : (core_done ? CHECK : WAIT);
      CHECK:   state_d = abort ? IDLE : ((hit || iter_q == max_q) ? DONE : ISSUE);
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // latched job parameters, nonce walk and held results
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      nonce_q  <= '0;
      max_q    <= '0;
      iter_q   <= '0;
      nvo_q    <= '0;
      tgt_q    <= '0;
      bounty_q <= '0;
      blocks_q <= '0;
      found_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          nonce_q  <= nonce_base;
          max_q    <= max_iter;
          tgt_q    <= target;
          blocks_q <= num_entradas;
          iter_q   <= '0;
          found_q  <= 1'b0;
        end
        WAIT: if (core_done && !abort) begin
          bounty_q <= core_hash;
          nvo_q    <= nonce_q;
          iter_q   <= iter_q + 1'b1;
        end
        CHECK: if (!abort) begin
          if (hit) found_q <= 1'b1;
          else if (iter_q != max_q) nonce_q <= nonce_q + 1'b1;
        end
        default: ;
      endcase
    end

  // state-decoded strobes and result wiring
  always_comb begin
    core_start       = state_q == ISSUE;
    busy             = state_q == ISSUE || state_q == WAIT || state_q == CHECK;
    fin              = state_q == DONE;
    core_nonce       = nonce_q;
    core_blocks      = blocks_q;
    found            = found_q;
    nonce_valido_out = nvo_q;
    bounty_out       = bounty_q;
    iter_count       = iter_q;
  end
endmodule

// File: tb/tb_nonce_sched.sv
// tb_nonce_sched: directed checks of nonce_sched against a 3-cycle core model
module tb_nonce_sched;
  logic        clk, reset, start, abort, core_start, core_done, busy, fin, found;
  logic [1:0]  num_entradas, core_blocks;
  logic [7:0]  target;
  logic [31:0] nonce_base, max_iter, core_nonce, nonce_valido_out, iter_count;
  logic [23:0] core_hash, bounty_out;
  logic [31:0] hit_nonce, pn;
  int          passed = 0, total = 0, cyc = 0, starts = 0, fins = 0, busy_cnt = 0;
  int          fin_cyc = 0, done_cyc = 0, lat = 0;
  int          s0, f0, b0;
  logic [31:0] seq[$];

  nonce_sched dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .num_entradas(num_entradas),
    .target(target), .nonce_base(nonce_base), .max_iter(max_iter), .core_start(core_start),
    .core_nonce(core_nonce), .core_blocks(core_blocks), .core_done(core_done),
    .core_hash(core_hash), .busy(busy), .fin(fin), .found(found),
    .nonce_valido_out(nonce_valido_out), .bounty_out(bounty_out), .iter_count(iter_count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (core_start) begin
      starts <= starts + 1;
      seq.push_back(core_nonce);
    end
    if (fin) begin
      fins <= fins + 1;
      fin_cyc <= cyc;
    end
    if (core_done) done_cyc <= cyc;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  // core model: result 3 cycles after core_start; only hit_nonce has a low top byte
  initial begin
    core_done = 0;
    core_hash = '0;
    forever begin
      @(posedge clk);
      #1;
      core_done = 0;
      if (reset) lat = 0;
      else begin
        if (lat > 0) begin
          lat--;
          if (lat == 0) begin
            core_done = 1;
            core_hash = (pn == hit_nonce) ? 24'h0F0000 : {8'hFF, pn[15:0]};
          end
        end
        if (core_start) begin
          lat = 3;
          pn = core_nonce;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic go(input logic [31:0] base, input logic [31:0] mi, input logic [7:0] tgt,
                    input logic [31:0] hn);
    hit_nonce = hn;
    nonce_base = base;
    max_iter = mi;
    target = tgt;
    num_entradas = 2'd2;
    s0 = seq.size();
    f0 = fins;
    b0 = busy_cnt;
    start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic wait_fin();
    int n = 0;
    while (fins == f0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (fins == f0) check("fin_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset = 1; start = 0; abort = 0; num_entradas = 0; target = 0;
    nonce_base = 0; max_iter = 0; hit_nonce = 32'hDEAD;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_fin", fin, 0);
    check("rst_found", found, 0);
    check("rst_core_start", core_start, 0);
    check("rst_iter", iter_count, 0);
    reset = 0;
    @(posedge clk);
    #1;

    // hit at nonce 8
    go(5, 100, 8'h10, 8);
    wait_fin();
    check("t1_starts", seq.size() - s0, 4);
    check("t1_n0", seq[s0], 5);
    check("t1_n1", seq[s0+1], 6);
    check("t1_n2", seq[s0+2], 7);
    check("t1_n3", seq[s0+3], 8);
    check("t1_found", found, 1);
    check("t1_nvo", nonce_valido_out, 8);
    check("t1_iter", iter_count, 4);
    check("t1_bounty", bounty_out, 24'h0F0000);
    check("t1_fins", fins - f0, 1);
    check("t1_fin_lag", fin_cyc - done_cyc, 2);
    check("t1_blocks", core_blocks, 2);
    repeat (4) @(negedge clk);
    check("t1_hold_found", found, 1);
    check("t1_hold_iter", iter_count, 4);

    // budget exhausted without a hit
    go(5, 3, 8'h0F, 8);
    wait_fin();
    check("t2_found", found, 0);
    check("t2_iter", iter_count, 3);
    check("t2_nvo", nonce_valido_out, 7);
    check("t2_bounty_top", bounty_out[23:16], 8'hFF);
    check("t2_fins", fins - f0, 1);

    // nonce wraps past FFFFFFFF
    go(32'hFFFFFFFE, 100, 8'h10, 1);
    wait_fin();
    check("t3_starts", seq.size() - s0, 4);
    check("t3_n0", seq[s0], 32'hFFFFFFFE);
    check("t3_n1", seq[s0+1], 32'hFFFFFFFF);
    check("t3_n2", seq[s0+2], 32'h0);
    check("t3_n3", seq[s0+3], 32'h1);
    check("t3_found", found, 1);
    check("t3_iter", iter_count, 4);

    // zero budget: straight to DONE
    go(9, 0, 8'h10, 9);
    check("t4_fin_now", fin, 1);
    wait_fin();
    check("t4_starts", seq.size() - s0, 0);
    check("t4_found", found, 0);
    check("t4_iter", iter_count, 0);
    check("t4_busy", busy_cnt - b0, 0);
    check("t4_fins", fins - f0, 1);

    // abort during WAIT of the 2nd nonce, late core_done must be ignored
    go(5, 100, 8'h10, 32'hDEAD);
    begin
      int n = 0;
      while (seq.size() - s0 < 2 && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    check("t5_reach2", seq.size() - s0, 2);
    @(negedge clk);
    abort = 1;
    @(posedge clk);
    #1 abort = 0;
    check("t5_busy", busy, 0);
    check("t5_found", found, 0);
    repeat (8) @(negedge clk);
    check("t5_nofin", fins - f0, 0);
    check("t5_iter", iter_count, 1);
    check("t5_nvo", nonce_valido_out, 5);
    go(20, 100, 8'h10, 20);
    wait_fin();
    check("t5_found2", found, 1);
    check("t5_nvo2", nonce_valido_out, 20);
    check("t5_iter2", iter_count, 1);

    // asynchronous reset mid-WAIT
    go(40, 100, 8'h10, 41);
    begin
      int n = 0;
      while (seq.size() == s0 && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    @(negedge clk);
    #2 reset = 1;
    #1;
    check("t6_busy", busy, 0);
    check("t6_core_nonce", core_nonce, 0);
    check("t6_nvo", nonce_valido_out, 0);
    check("t6_bounty", bounty_out, 0);
    check("t6_iter", iter_count, 0);
    check("t6_blocks", core_blocks, 0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    check("t6_nofin", fins - f0, 0);
    @(posedge clk);
    #1;
    go(30, 100, 8'h10, 31);
    wait_fin();
    check("t6_n0", seq[s0], 30);
    check("t6_found", found, 1);
    check("t6_nvo2", nonce_valido_out, 31);
    check("t6_iter2", iter_count, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
